// File: rtl/counter169_monitor.sv
// Passive checker for a 4-bit up/down counter with parallel load and ripple carry.
// Optional macro COUNTER169_MONITOR_RESYNC_EN: re-seed the model from observed q on a mismatch.
module counter169_monitor (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       load,
    input  logic       ud,
    input  logic       ent,
    input  logic       enp,
    input  logic [3:0] d,
    input  logic [3:0] q,
    input  logic       rco,
    output logic       synced,
    output logic       error,
    output logic [7:0] err_count,
    output logic [15:0] check_count,
    output logic [3:0] first_q,
    output logic [3:0] first_exp
);

    localparam logic [0:0] UNSYNC = 1'b0;
    localparam logic [0:0] TRACK  = 1'b1;

    logic [0:0]  state, state_n;
    logic [3:0]  model, model_n;
    logic        error_n;
    logic [7:0]  err_count_n;
    logic [15:0] check_count_n;
    logic [3:0]  first_q_n, first_exp_n;
    logic [3:0]  base;
    logic        exp_rco_c;
    logic        mismatch_c;

    // Reference model, checker and statistics next-state
    always_comb begin
        state_n       = state;
        model_n       = model;
        error_n       = error;
        err_count_n   = err_count;
        check_count_n = check_count;
        first_q_n     = first_q;
        first_exp_n   = first_exp;

        exp_rco_c  = !(!ent && ((ud && (model == 4'd15)) || (!ud && (model == 4'd0))));
        mismatch_c = (state == TRACK) && ((q != model) || (rco != exp_rco_c));

        base = model;
`ifdef COUNTER169_MONITOR_RESYNC_EN
        if (mismatch_c) base = q;
`endif

        case (state)
            UNSYNC: begin
                if (!load) begin
                    model_n = d;
                    state_n = TRACK;
                end
            end
            TRACK: begin
                check_count_n = check_count + 16'd1;
                if (!load)
                    model_n = d;
                else if (!ent && !enp)
                    model_n = ud ? base + 4'd1 : base - 4'd1;
                else
                    model_n = base;

                if (mismatch_c) begin
                    error_n = 1'b1;
                    if (err_count != 8'd255) err_count_n = err_count + 8'd1;
                    if (err_count == 8'd0) begin
                        first_q_n   = q;
                        first_exp_n = model;
                    end
                end
            end
            default: state_n = UNSYNC;
        endcase
    end

    // State and registered outputs; reset and clear override everything
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            state       <= UNSYNC;
            model       <= 4'd0;
            synced      <= 1'b0;
            error       <= 1'b0;
            err_count   <= 8'd0;
            check_count <= 16'd0;
            first_q     <= 4'd0;
            first_exp   <= 4'd0;
        end else begin
            state       <= state_n;
            model       <= model_n;
            synced      <= (state_n == TRACK);
            error       <= error_n;
            err_count   <= err_count_n;
            check_count <= check_count_n;
            first_q     <= first_q_n;
            first_exp   <= first_exp_n;
        end
    end

endmodule

// File: tb/tb_counter169_monitor.sv
// Directed self-checking bench for counter169_monitor.
// q/rco are driven as the observed counter presents them just before each edge.
module tb_counter169_monitor;

    logic       clock = 1'b0;
    logic       reset, clear, load, ud, ent, enp, rco;
    logic [3:0] d, q;
    logic       synced, error;
    logic [7:0] err_count;
    logic [15:0] check_count;
    logic [3:0] first_q, first_exp;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    counter169_monitor dut (
        .clock(clock), .reset(reset), .clear(clear), .load(load), .ud(ud),
        .ent(ent), .enp(enp), .d(d), .q(q), .rco(rco),
        .synced(synced), .error(error), .err_count(err_count),
        .check_count(check_count), .first_q(first_q), .first_exp(first_exp)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one set of inputs across one rising edge, then settle
    task automatic step(input logic l, input logic u, input logic t, input logic p,
                        input logic [3:0] dd, input logic [3:0] qq, input logic r);
        load = l; ud = u; ent = t; enp = p; d = dd; q = qq; rco = r;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_synced"}, 16'(synced), 16'd0);
        chk({tag, "_error"}, 16'(error), 16'd0);
        chk({tag, "_err_count"}, 16'(err_count), 16'd0);
        chk({tag, "_check_count"}, check_count, 16'd0);
        chk({tag, "_first_q"}, 16'(first_q), 16'd0);
        chk({tag, "_first_exp"}, 16'(first_exp), 16'd0);
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0;
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 1'b1);
        chk_zero("reset");

        // Reset wins over a simultaneous load
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'd5, 4'd0, 1'b1);
        chk("reset_wins_synced", 16'(synced), 16'd0);
        reset = 1'b0;

        step(1'b1, 1'b1, 1'b1, 1'b1, 4'd5, 4'd0, 1'b1);
        chk("unsync_hold_synced", 16'(synced), 16'd0);
        chk("unsync_no_check", check_count, 16'd0);

        // Load 14, then count up through the 15 -> 0 wrap
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'd14, 4'd0, 1'b1);
        chk("load_synced", 16'(synced), 16'd1);
        chk("load_no_check", check_count, 16'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd14, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd15, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0,  1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1,  1'b1);
        chk("up_check_count", check_count, 16'd4);
        chk("up_error", 16'(error), 16'd0);
        chk("up_synced", 16'(synced), 16'd1);

        // Hold cases: model stays 2
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 4'd2, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd2, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 4'd2, 1'b1);
        chk("hold_error", 16'(error), 16'd0);

        // Count down through 0 -> 15; rco low only at model 0
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd2,  1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1,  1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0,  1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd15, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd14, 1'b1);
        chk("down_error", 16'(error), 16'd0);
        chk("down_check_count", check_count, 16'd12);

        // Load has priority over counting; model 13 -> 5
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 4'd13, 1'b1);
        chk("load_prio_error", 16'(error), 16'd0);

        // Off-by-one DUT: shows 7 where 6 is expected
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd5, 1'b1);
        chk("pre_fault_error", 16'(error), 16'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd7, 1'b1);
        chk("fault_error", 16'(error), 16'd1);
        chk("fault_err_count", 16'(err_count), 16'd1);
        chk("fault_first_q", 16'(first_q), 16'd7);
        chk("fault_first_exp", 16'(first_exp), 16'd6);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd8, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd9, 1'b1);
`ifdef COUNTER169_MONITOR_RESYNC_EN
        chk("fault_err_total", 16'(err_count), 16'd1);
`else
        chk("fault_err_total", 16'(err_count), 16'd3);
`endif
        chk("fault_first_q_held", 16'(first_q), 16'd7);
        chk("fault_check_count", check_count, 16'd17);

        // Clear behaves like reset
        clear = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 4'd9, 1'b1);
        chk_zero("clear1");
        clear = 1'b0;

        // Missing ripple carry at model 15
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'd14, 4'd0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd14, 1'b1);
        chk("rco_pre_error", 16'(error), 16'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd15, 1'b1);
        chk("rco_error", 16'(error), 16'd1);
        chk("rco_err_count", 16'(err_count), 16'd1);
        chk("rco_first_q", 16'(first_q), 16'd15);
        chk("rco_first_exp", 16'(first_exp), 16'd15);

        // 300 forced rco mismatches with model held at 0
        for (int i = 0; i < 300; i++)
            step(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0);
        chk("sat_err_count", 16'(err_count), 16'd255);
        chk("sat_check_count", check_count, 16'd302);
        chk("sat_first_q", 16'(first_q), 16'd15);
        chk("sat_error", 16'(error), 16'd1);

        clear = 1'b1;
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 1'b1);
        chk_zero("clear2");
        clear = 1'b0;
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 1'b1);
        chk("post_clear_unsync", 16'(synced), 16'd0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'd4, 4'd0, 1'b1);
        chk("post_clear_resync", 16'(synced), 16'd1);
        chk("post_clear_check_count", check_count, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
